// File: rtl/psubsb_pkg.sv
// psubsb_pkg
// Shared definitions for the serial packed saturating subtractor:
//   - FSM state encoding (IDLE / CALC / DONE)
//   - lane geometry (LANE_W, NUM_LANES)
//   - saturation constants (SAT_POS, SAT_NEG)
//   - helper functions for lane overflow detection and the saturation value
package psubsb_pkg;

  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow of a - b: operands differ in sign and the result's sign
  // differs from the minuend's.
  function automatic logic lane_ovf(input logic [LANE_W-1:0] a,
                                    input logic [LANE_W-1:0] b,
                                    input logic [LANE_W-1:0] diff);
    return (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
  endfunction

  // Clamp toward the minuend's sign.
  function automatic logic [LANE_W-1:0] lane_sat(input logic [LANE_W-1:0] a);
    return a[LANE_W-1] ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/CLA_4bit.sv
// CLA_4bit
// 4-bit carry-lookahead adder: Sum = A + B + Cin (modulo 16).
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
module CLA_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry computed directly from generate/propagate terms.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);

  assign Sum = p ^ c;

endmodule

// File: rtl/psubsb_serial.sv
// psubsb_serial
// Serial packed saturating subtractor. Result = A - B per signed 4-bit lane,
// one lane per clock through a single shared CLA_4bit, lane 0 first.
// Optional feature macro: PSUBSB_SAT_FLAG_EN adds the sat_flags output.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : operand pair offered
//   in_ready   : block can accept operands (IDLE only)
//   A, B       : minuend / subtrahend, four signed 4-bit lanes
//   out_valid  : Result valid (DONE only)
//   out_ready  : consumer accepts Result
//   Result     : registered per-lane saturated difference A - B
//   sat_flags  : per-lane saturation indicator (PSUBSB_SAT_FLAG_EN only)
module psubsb_serial
  import psubsb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Result
`ifdef PSUBSB_SAT_FLAG_EN
  ,
  output logic [3:0]  sat_flags
`endif
);

  localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] result_q;
  logic        in_ready_q;
  logic        out_valid_q;
`ifdef PSUBSB_SAT_FLAG_EN
  logic [3:0]  sat_q;
`endif

  logic [LANE_W-1:0] a_lane;
  logic [LANE_W-1:0] b_lane;
  logic [LANE_W-1:0] diff;
  logic              ovf_d;
  logic [LANE_W-1:0] lane_d;

  // Current lane operands taken from the captured copies, so input changes
  // after acceptance never reach the datapath.
  assign a_lane = a_q[lane_q*LANE_W +: LANE_W];
  assign b_lane = b_q[lane_q*LANE_W +: LANE_W];

  // Subtraction as A + ~B + 1 on the shared adder.
  CLA_4bit u_cla (
    .A   (a_lane),
    .B   (~b_lane),
    .Cin (1'b1),
    .Sum (diff)
  );

  assign ovf_d  = lane_ovf(a_lane, b_lane, diff);
  assign lane_d = ovf_d ? lane_sat(a_lane) : diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= 2'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      result_q    <= 16'h0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef PSUBSB_SAT_FLAG_EN
      sat_q       <= 4'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            result_q   <= 16'h0000;
            lane_q     <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
`ifdef PSUBSB_SAT_FLAG_EN
            sat_q      <= 4'h0;
`endif
          end
        end

        CALC: begin
          result_q[lane_q*LANE_W +: LANE_W] <= lane_d;
`ifdef PSUBSB_SAT_FLAG_EN
          sat_q[lane_q] <= ovf_d;
`endif
          if (lane_q == LAST_LANE) begin
            lane_q      <= 2'd0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            lane_q <= lane_q + 2'd1;
          end
        end

        DONE: begin
          // Result and flags simply hold; leaving DONE does not touch them.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          lane_q      <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
`ifdef PSUBSB_SAT_FLAG_EN
  assign sat_flags = sat_q;
`endif

endmodule

// File: tb/tb_psubsb_serial.sv
// tb_psubsb_serial
// Directed-vector bench for psubsb_serial. Build with +define+PSUBSB_SAT_FLAG_EN
// to also check sat_flags.
module tb_psubsb_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
`ifdef PSUBSB_SAT_FLAG_EN
  logic [3:0]  sat_flags;
`endif

  int checks   = 0;
  int failures = 0;

  psubsb_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result)
`ifdef PSUBSB_SAT_FLAG_EN
    ,
    .sat_flags (sat_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid after an accepting edge; lat = edges taken,
  // 0 if the bound expired.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat == 0) lat = k;
      if (lat != 0) break;
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp_f);
`ifdef PSUBSB_SAT_FLAG_EN
    check_eq(tag, {12'h000, sat_flags}, {12'h000, exp_f});
`else
    if (exp_f === 4'hx) $display("unused %s", tag);
`endif
  endtask

  // One full operation with out_ready held high; starts and ends in IDLE.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_r,
                        input logic [3:0] exp_f);
    int lat;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b;     // must not disturb the captured operands
    check_eq({tag, "_busy"}, {15'h0, in_ready}, 16'h0000);
    wait_out(lat);
    check_eq({tag, "_lat"}, 16'(lat), 16'd4);
    check_eq({tag, "_res"}, Result, exp_r);
    check_eq({tag, "_rdy_done"}, {15'h0, in_ready}, 16'h0000);
    check_flags({tag, "_flags"}, exp_f);
    @(posedge clk);
    #1;
    check_eq({tag, "_ov_idle"}, {15'h0, out_valid}, 16'h0000);
    check_eq({tag, "_rdy_idle"}, {15'h0, in_ready}, 16'h0001);
    check_eq({tag, "_res_keep"}, Result, exp_r);
    check_flags({tag, "_flags_keep"}, exp_f);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; A = 16'h0; B = 16'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy", {15'h0, in_ready}, 16'h0001);
    check_eq("rst_ov", {15'h0, out_valid}, 16'h0000);
    check_eq("rst_res", Result, 16'h0000);
    check_flags("rst_flags", 4'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic",  16'h3521, 16'h1111, 16'h2410, 4'h0);
    run_op("satpos", 16'h7777, 16'h8888, 16'h7777, 4'hF);
    run_op("satneg", 16'h8888, 16'h1111, 16'h8888, 4'hF);
    run_op("mixed",  16'h70F8, 16'h8010, 16'h70E8, 4'b1000);

    // Back-pressure: hold out_ready low in DONE while poking the inputs.
    @(negedge clk);
    out_ready = 1'b0; A = 16'h3521; B = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("hold_lat", 16'(lat), 16'd4);
    check_eq("hold_res0", Result, 16'h2410);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold_res", Result, 16'h2410);
      check_eq("hold_rdy", {15'h0, in_ready}, 16'h0000);
      check_eq("hold_ov", {15'h0, out_valid}, 16'h0001);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_ov", {15'h0, out_valid}, 16'h0000);
    check_eq("release_rdy", {15'h0, in_ready}, 16'h0001);
    check_eq("release_res", Result, 16'h2410);

    // Reset while lane 2 is being processed.
    @(negedge clk);
    A = 16'h3521; B = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("mid_partial", Result, 16'h0010);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ov", {15'h0, out_valid}, 16'h0000);
    check_eq("mid_rst_res", Result, 16'h0000);
    check_eq("mid_rst_rdy", {15'h0, in_ready}, 16'h0001);
    check_flags("mid_rst_flags", 4'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 16'h0001, 16'h0002, 16'h000F, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psubsb_serial.md
PSUBSB_SERIAL -- requirements
Module: psubsb_serial

Interface
REQ-001 The block SHALL have a single clock and asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have the port `in_valid  input  1  operand pair offered`.
REQ-003 The block SHALL have the port `in_ready  output  1  block can accept operands`.
REQ-004 The block SHALL have the ports `A  input  16  minuend, four signed 4-bit lanes` and `B  input  16  subtrahend, four signed 4-bit lanes`.
REQ-005 The block SHALL have the port `out_valid  output  1  Result valid`.
REQ-006 The block SHALL have the port `out_ready  input  1  consumer accepts Result`.
REQ-007 The block SHALL have the port `Result  output  16  registered per-lane saturated difference A-B`.
REQ-008 The block SHALL have the port `sat_flags  output  4  per-lane saturation indicator, bit i = lane i`; this port is present only under PSUBSB_SAT_FLAG_EN.

Function
REQ-009 The FSM SHALL have exactly three states, IDLE, CALC and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-010 IDLE: on a clk edge with in_valid=1, the block SHALL capture A and B, clear Result (and sat_flags), set lane index to 0, and enter CALC; otherwise it SHALL stay in IDLE.
REQ-011 CALC: each cycle the block SHALL process one lane, lane 0 (bits 3:0) first through lane 3 (bits 15:12), as diff = A_n + ~B_n + 1 using one shared 4-bit adder.
REQ-012 Overflow SHALL be detected as sign(A_n) != sign(B_n) and sign(diff) != sign(A_n); on overflow the lane SHALL become 4'b0111 if A_n is non-negative and 4'b1000 if A_n is negative; otherwise the lane SHALL be diff[3:0].
REQ-013 After lane 3 is written, the FSM SHALL enter DONE; out_valid SHALL rise exactly 4 clk edges after the accepting edge.
REQ-014 DONE: Result SHALL be held stable while out_ready=0; on an edge with out_ready=1 the FSM SHALL return to IDLE and Result SHALL keep its value.
REQ-015 in_valid SHALL be ignored outside IDLE, and A/B changes after acceptance SHALL NOT affect Result.
REQ-016 The block SHALL accept at most one operation every 6 cycles with out_ready held at 1; there is no bypass from DONE to accept.
REQ-017 Lanes SHALL be independent: no carry propagates between lanes.

Reset
REQ-018 While rst=1, the block SHALL set state=IDLE, lane index=0, Result=16'h0000, sat_flags=4'h0, out_valid=0 and in_ready=1, asynchronously.
REQ-019 Reset asserted mid-CALC or in DONE SHALL abort the operation with no partial Result retained, and the first operation after release SHALL be accepted normally.

Configuration
REQ-020 With PSUBSB_SAT_FLAG_EN defined, sat_flags bit n SHALL be set when lane n saturates, cleared on acceptance, and held with Result in DONE.
REQ-021 Without PSUBSB_SAT_FLAG_EN, the sat_flags port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 A shared package psubsb_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE), LANE_W=4, NUM_LANES=4, SAT_POS=4'b0111 and SAT_NEG=4'b1000.
REQ-023 The shared lane adder SHALL be one instance of the existing CLA_4bit sub-module with Cin=1 and B input inverted; there SHALL be no other sub-modules.

Verification
REQ-024 The bench SHALL drive A=16'h3521, B=16'h1111 -> Result=16'h2410, sat_flags=4'h0, with out_valid 4 cycles after accept.
REQ-025 The bench SHALL drive A=16'h7777, B=16'h8888 -> Result=16'h7777 (positive saturation in all lanes), sat_flags=4'hF.
REQ-026 The bench SHALL drive A=16'h8888, B=16'h1111 -> Result=16'h8888 (negative saturation), sat_flags=4'hF.
REQ-027 The bench SHALL drive A=16'h70F8, B=16'h8010 -> Result=16'h70E8, sat_flags=4'b1000.
REQ-028 The bench SHALL hold out_ready=0 for 3 cycles in DONE while toggling in_valid and A/B -> Result is stable, in_ready=0, and no new acceptance occurs; then out_ready=1 -> IDLE on the next edge.
REQ-029 The bench SHALL assert rst while CALC is processing lane 2 -> out_valid=0, Result=16'h0000 and in_ready=1 immediately; after release, A=16'h0001, B=16'h0002 -> Result=16'h000F.
